ifetch_resp: RTL and testbench
==============================

Name: ifetch_resp

Overview:
- Responder for the fetch-stage PC stream: accepts (pc, valid) from the PC generator and backpressures it with ready.
- Issues one instruction-memory read per accepted PC and captures the returned word.
- Buffers (pc, instr) pairs in an in-order queue that feeds decode.
- Flushes on mispredict and discards any in-flight stale response.

Parameters:
- DEPTH, 4, fetch queue entries; power of two, >= 2.
- PC_W, 48, PC / memory address width.
- INSTR_W, 32, instruction width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- pc_in  input  PC_W  PC offered by the fetch stage.
- pc_valid  input  1  pc_in is valid this cycle.
- ready  output  1  responder accepts pc_in this cycle.
- mispred  input  1  flush request from the back end.
- mem_req  output  1  one-cycle read strobe to instruction memory.
- mem_addr  output  PC_W  read address; valid while mem_req = 1.
- mem_rvalid  input  1  read data return, exactly one per mem_req.
- mem_rdata  input  INSTR_W  returned instruction word.
- dec_valid  output  1  queue head is valid.
- dec_pc  output  PC_W  PC of the queue head.
- dec_instr  output  INSTR_W  instruction at the queue head.
- dec_misalign  output  1  head PC has pc[1:0] != 0.
- dec_ready  input  1  decode consumes the head this cycle.

Behaviour:
- Reset, synchronous and checked first: state = IDLE, count = 0, rd_ptr = wr_ptr = 0, mem_req = 0, mem_addr = 0, ready = 0, dec_valid = 0.
  - dec_pc, dec_instr and dec_misalign reset to 0.
  - A reset mid-WAIT or mid-DROP returns to IDLE. A response arriving the cycle after reset is ignored.
- FSM states:
  - IDLE: no outstanding read.
  - REQ: mem_req asserted.
  - WAIT: awaiting mem_rvalid.
  - DROP: awaiting a stale response after a flush.
- Acceptance: ready = (state == IDLE) && (count < DEPTH) && !mispred && !reset. This is combinational from registered state plus mispred.
- Handshake: a transfer occurs at the edge where pc_valid && ready.
  - The PC is latched into pc_q and the FSM goes IDLE -> REQ.
- REQ, exactly one cycle: mem_req = 1 and mem_addr = pc_q. Next state is WAIT.
  - If mispred is high in REQ, the request is still issued and the next state is DROP.
- WAIT, on mem_rvalid: push {pc_q, mem_rdata, pc_q[1:0] != 0} at wr_ptr and go to IDLE.
  - Room is guaranteed because acceptance required count < DEPTH and count cannot increase while in REQ or WAIT.
- DROP: hold until mem_rvalid, discard the data, then go to IDLE.
- Flush (mispred = 1 at an edge):
  - count = 0 and rd_ptr = wr_ptr = 0, so dec_valid = 0 the next cycle.
  - A pop at the same edge is cancelled.
  - WAIT without mem_rvalid -> DROP. WAIT with mem_rvalid that same edge -> data discarded, go to IDLE.
  - REQ -> DROP.
  - IDLE and DROP are unchanged (DROP still waits for its response).
- Queue:
  - Circular buffer; pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0.
  - count is log2(DEPTH)+1 bits.
  - dec_valid = (count != 0); the head fields are read from rd_ptr.
  - Pop when dec_valid && dec_ready.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
  - At full: ready = 0, and pops are still allowed.
  - At empty: dec_ready is ignored.
- Latency: accept at edge N -> mem_req high in cycle N+1 -> mem_rvalid at the earliest in cycle N+2 -> dec_valid high from the cycle after the mem_rvalid edge.
  - No bypass path.
  - Minimum accept-to-accept spacing is 3 cycles at 1-cycle memory latency.
- Ordering: one outstanding read at a time, so queue order equals PC acceptance order.
- Misaligned PC: still fetched at the given address and flagged via dec_misalign. No trap is generated here.

Test Plan:
- Single fetch: reset, pc_in = 0x1000 with pc_valid, memory returns 0x00500093 one cycle after mem_req -> mem_addr = 0x1000; then dec_valid = 1, dec_pc = 0x1000, dec_instr = 0x00500093, dec_misalign = 0.
- Fill and backpressure: dec_ready = 0, feed PCs 0x0, 0x4, 0x8, 0xC, 0x10 -> four entries queued and ready = 0 while count = 4; 0x10 is held.
  - Then dec_ready = 1 -> 0x10 is accepted, and decode receives 0x0..0x10 in order with correct pointer wrap.
- Flush during WAIT: accept 0x2000, assert mispred before mem_rvalid, memory returns 0xDEADBEEF 3 cycles later -> nothing is pushed and ready stays 0 until that return.
  - A subsequent pc_in = 0x3000 is the next dec_pc.
- Flush with queued entries and same-cycle pop plus rvalid: 2 entries queued, WAIT active, and mispred, dec_ready and mem_rvalid high together -> count = 0, state IDLE, dec_valid = 0 next cycle.
- Misaligned: pc_in = 0x1002 -> mem_addr = 0x1002, dec_misalign = 1.
- Reset mid-WAIT: accept 0x4000, assert reset, memory returns 0x13 the cycle after -> count = 0, dec_valid = 0, ready = 1 after reset drops.

Source files
------------

// File: rtl/ifetch_resp.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_resp
// Brief    : Fetch responder - accepts PCs, issues one instruction read per
//            PC, and queues (pc, instr) pairs in order for decode.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_resp #(
   parameter int DEPTH   = 4,
   parameter int PC_W    = 48,
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [PC_W-1:0]    pc_in,
   input  logic               pc_valid,
   output logic               ready,
   input  logic               mispred,
   output logic               mem_req,
   output logic [PC_W-1:0]    mem_addr,
   input  logic               mem_rvalid,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic               dec_valid,
   output logic [PC_W-1:0]    dec_pc,
   output logic [INSTR_W-1:0] dec_instr,
   output logic               dec_misalign,
   input  logic               dec_ready
);

   localparam int                 c_PTR_W     = $clog2(DEPTH);
   localparam int                 c_CNT_W     = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DROP = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [PC_W-1:0]      r_pc_q;
   logic [c_PTR_W-1:0]   r_rd_ptr;
   logic [c_PTR_W-1:0]   r_wr_ptr;
   logic [c_CNT_W-1:0]   r_count;
   logic [PC_W-1:0]      r_q_pc    [DEPTH];
   logic [INSTR_W-1:0]   r_q_instr [DEPTH];
   logic [DEPTH-1:0]     r_q_mis;
   logic                 w_accept;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_dec_valid;

   assign ready       = (r_state == S_IDLE) && (r_count < c_DEPTH_CNT) && !mispred && !reset;
   assign w_accept    = pc_valid && ready;
   // A response landing together with a flush is dropped, never queued.
   assign w_push      = (r_state == S_WAIT) && mem_rvalid && !mispred;
   assign w_dec_valid = (r_count != '0);
   assign w_pop       = w_dec_valid && dec_ready && !mispred;
   assign mem_addr    = r_pc_q;

   always_comb begin
      w_state_nxt = r_state;
      mem_req     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = S_REQ;
         end
         S_REQ: begin
            mem_req     = 1'b1;
            w_state_nxt = mispred ? S_DROP : S_WAIT;
         end
         S_WAIT: begin
            if (mem_rvalid)   w_state_nxt = S_IDLE;
            else if (mispred) w_state_nxt = S_DROP;
         end
         S_DROP: begin
            if (mem_rvalid) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_pc_q  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) r_pc_q <= pc_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || mispred) begin
         r_count  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage needs no reset; the head is masked while empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_pc[r_wr_ptr]    <= r_pc_q;
         r_q_instr[r_wr_ptr] <= mem_rdata;
         r_q_mis[r_wr_ptr]   <= (r_pc_q[1:0] != 2'b00);
      end
   end

   assign dec_valid    = w_dec_valid;
   assign dec_pc       = w_dec_valid ? r_q_pc[r_rd_ptr]    : '0;
   assign dec_instr    = w_dec_valid ? r_q_instr[r_rd_ptr] : '0;
   assign dec_misalign = w_dec_valid && r_q_mis[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_ifetch_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_resp
// Brief    : Self-checking bench for ifetch_resp against a transaction-level
//            queue model with a bench-side instruction memory responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_resp;

   localparam int DEPTH   = 4;
   localparam int PC_W    = 48;
   localparam int INSTR_W = 32;

   logic               clk = 1'b0;
   logic               reset;
   logic [PC_W-1:0]    pc_in;
   logic               pc_valid;
   logic               ready;
   logic               mispred;
   logic               mem_req;
   logic [PC_W-1:0]    mem_addr;
   logic               mem_rvalid;
   logic [INSTR_W-1:0] mem_rdata;
   logic               dec_valid;
   logic [PC_W-1:0]    dec_pc;
   logic [INSTR_W-1:0] dec_instr;
   logic               dec_misalign;
   logic               dec_ready;

   ifetch_resp #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) u_dut (
      .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid), .ready(ready),
      .mispred(mispred), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .dec_valid(dec_valid),
      .dec_pc(dec_pc), .dec_instr(dec_instr), .dec_misalign(dec_misalign),
      .dec_ready(dec_ready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic               mis;
   } entry_t;

   // Model: a read is either due this cycle, owed by memory, or none.
   entry_t             m_q[$];
   logic               m_req, m_owed, m_disc, m_acc;
   logic [PC_W-1:0]    m_pc;
   int                 rsp_cnt, rsp_lat;
   logic               use_dir;
   logic [INSTR_W-1:0] dir_data, rsp_data;
   int                 checks, errors;
   bit                 chk_en;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic rst_i, input logic pv, input logic [PC_W-1:0] pc,
                      input logic mp, input logic dr);
      logic   exp_ready;
      logic   push;
      entry_t e;
      reset = rst_i; pc_valid = pv; pc_in = pc; mispred = mp; dec_ready = dr;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (rsp_cnt > 0) begin
         rsp_cnt--;
         if (rsp_cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rsp_data;
         end else if (rst_i) begin
            rsp_cnt = 1;
         end
      end
      @(negedge clk);
      exp_ready = !m_req && !m_owed && (m_q.size() < DEPTH) && !mp && !rst_i;
      if (chk_en) begin
         chk("ready", ready, exp_ready);
         chk("mem_req", mem_req, m_req);
         if (m_req) chk("mem_addr", mem_addr, m_pc);
         chk("dec_valid", dec_valid, m_q.size() > 0);
         if (m_q.size() > 0) begin
            chk("dec_pc", dec_pc, m_q[0].pc);
            chk("dec_instr", dec_instr, m_q[0].instr);
            chk("dec_misalign", dec_misalign, m_q[0].mis);
         end
      end
      if (m_req) begin
         rsp_cnt  = rst_i ? 1 : rsp_lat;
         rsp_data = use_dir ? dir_data : $urandom;
      end
      m_acc = 1'b0;
      push  = 1'b0;
      if (rst_i) begin
         m_q.delete();
         m_req = 1'b0; m_owed = 1'b0; m_disc = 1'b0; m_pc = '0;
      end else begin
         m_acc = exp_ready && pv;
         if (m_req) begin
            m_req = 1'b0; m_owed = 1'b1; m_disc = mp;
         end else if (m_owed && mem_rvalid) begin
            m_owed = 1'b0;
            push   = !m_disc && !mp;
         end else if (m_owed && mp) begin
            m_disc = 1'b1;
         end
         if (mp) begin
            m_q.delete();
         end else begin
            if (m_q.size() > 0 && dr) void'(m_q.pop_front());
            if (push) begin
               e.pc = m_pc; e.instr = mem_rdata; e.mis = (m_pc[1:0] != 2'b00);
               m_q.push_back(e);
            end
         end
         if (m_acc) begin
            m_pc  = pc;
            m_req = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [PC_W-1:0] pc, input logic dr);
      int n = 0;
      m_acc = 1'b0;
      while (!m_acc && n < 20) begin
         cyc(1'b0, 1'b1, pc, 1'b0, dr);
         n++;
      end
      if (!m_acc) begin
         checks++;
         errors++;
         $error("FAIL offer_timeout observed no-accept expected accept pc %h", pc);
      end
   endtask

   task automatic idle(input int n, input logic dr);
      repeat (n) cyc(1'b0, 1'b0, '0, 1'b0, dr);
   endtask

   initial begin
      logic [63:0]     r64;
      logic [PC_W-1:0] rpc;
      reset = 1'b1; pc_valid = 1'b0; pc_in = '0; mispred = 1'b0;
      mem_rvalid = 1'b0; mem_rdata = '0; dec_ready = 1'b0;
      m_req = 1'b0; m_owed = 1'b0; m_disc = 1'b0; m_acc = 1'b0; m_pc = '0;
      rsp_cnt = 0; rsp_lat = 1; use_dir = 1'b0; dir_data = '0; rsp_data = '0;
      checks = 0; errors = 0; chk_en = 1'b0;

      cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
      chk_en = 1'b1;
      cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
      chk("rst_mem_addr", mem_addr, 64'h0);
      chk("rst_dec_pc", dec_pc, 64'h0);
      chk("rst_dec_instr", dec_instr, 64'h0);
      chk("rst_dec_misalign", dec_misalign, 64'h0);

      // single fetch
      use_dir = 1'b1; dir_data = 32'h0050_0093; rsp_lat = 1;
      offer(48'h1000, 1'b0);
      idle(3, 1'b0);
      chk("single_pc", dec_pc, 64'h1000);
      chk("single_instr", dec_instr, 64'h0050_0093);
      idle(2, 1'b1);

      // fill to full, hold the fifth PC, then drain across the wrap
      use_dir = 1'b0;
      offer(48'h0, 1'b0);
      offer(48'h4, 1'b0);
      offer(48'h8, 1'b0);
      offer(48'hC, 1'b0);
      repeat (6) cyc(1'b0, 1'b1, 48'h10, 1'b0, 1'b0);
      chk("full_ready", ready, 64'h0);
      offer(48'h10, 1'b1);
      idle(8, 1'b1);

      // flush while waiting on a slow response
      rsp_lat = 3; use_dir = 1'b1; dir_data = 32'hDEAD_BEEF;
      offer(48'h2000, 1'b1);
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
      idle(2, 1'b1);
      rsp_lat = 1; use_dir = 1'b0;
      offer(48'h3000, 1'b0);
      idle(3, 1'b0);
      chk("flush_next_pc", dec_pc, 64'h3000);
      idle(2, 1'b1);

      // flush coinciding with pop and response
      offer(48'h5000, 1'b0);
      offer(48'h5004, 1'b0);
      idle(2, 1'b0);
      offer(48'h5008, 1'b0);
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
      chk("flush_dec_valid", dec_valid, 64'h0);

      // misaligned PC
      offer(48'h1002, 1'b0);
      idle(3, 1'b0);
      chk("misalign_flag", dec_misalign, 64'h1);
      idle(2, 1'b1);

      // reset while waiting; late response must be ignored
      rsp_lat = 3; use_dir = 1'b1; dir_data = 32'h13;
      offer(48'h4000, 1'b0);
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
      chk("rst_wait_ready", ready, 64'h1);
      chk("rst_wait_dec_valid", dec_valid, 64'h0);
      use_dir = 1'b0;

      // randomized traffic
      repeat (600) begin
         rsp_lat = $urandom_range(1, 4);
         r64 = {$urandom, $urandom};
         rpc = r64[PC_W-1:0];
         if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
         cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, rpc,
             $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
      end
      idle(10, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
